lsu_ahb_master: RTL and testbench

Single-outstanding AHB-Lite master that converts the core LSU valid/ready request/response handshake into AHB-Lite single transfers. It sits directly downstream of the core LSU port, inside the AHB subsystem, and drives the shared AHB-Lite bus that the UART and other slaves decode. It handles RV32I load/store width encoding, byte-lane steering for writes, and lane extraction with sign/zero extension for reads.

---
 rtl/lsu_ahb_master.sv | 144 ++++++++++++++
 tb/tb_lsu_ahb_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ahb_master.sv
// lsu_ahb_master
//   Single-outstanding AHB-Lite master. Converts the core LSU valid/ready
//   request/response handshake into AHB-Lite SINGLE transfers. It steers
//   store data onto the byte lanes, and it extracts and sign/zero-extends
//   load data.
//
// Ports
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   lsu_req_*        request channel: vld/rdy, wen, rwtyp (RV32I funct3),
//                    addr, wdata (LSB-aligned)
//   lsu_rsp_*        response channel: vld/rdy, rdata (extended), err
//   h*               AHB-Lite master interface (SINGLE, NONSEQ/IDLE only)
module lsu_ahb_master (
    input  logic        clk,
    input  logic        rstn,
    input  logic        lsu_req_vld,
    output logic        lsu_req_rdy,
    input  logic        lsu_req_wen,
    input  logic [2:0]  lsu_req_rwtyp,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_wdata,
    output logic        lsu_rsp_vld,
    input  logic        lsu_rsp_rdy,
    output logic [31:0] lsu_rsp_rdata,
    output logic        lsu_rsp_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state, state_nxt;
    logic        wen_q;
    logic [2:0]  typ_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_illegal;
    logic [31:0] wdata_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    // Reserved encodings, and half/word accesses that are not naturally aligned
    always_comb begin
        req_illegal = 1'b0;
        case (lsu_req_rwtyp)
            3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
            3'b001, 3'b101:         req_illegal = lsu_req_addr[0];
            3'b010:                 req_illegal = (lsu_req_addr[1:0] != 2'b00);
            default:                req_illegal = 1'b0;
        endcase
    end

    // Replicate store data so the slave finds it on whichever lane it decodes
    always_comb begin
        wdata_rep = lsu_req_wdata;
        case (lsu_req_rwtyp[1:0])
            2'b00:   wdata_rep = {4{lsu_req_wdata[7:0]}};
            2'b01:   wdata_rep = {2{lsu_req_wdata[15:0]}};
            default: wdata_rep = lsu_req_wdata;
        endcase
    end

    // Select the load lane from the address, then extend; rwtyp[2] marks unsigned
    always_comb begin
        ld_byte = hrdata[7:0];
        case (addr_q[1:0])
            2'b00:   ld_byte = hrdata[7:0];
            2'b01:   ld_byte = hrdata[15:8];
            2'b10:   ld_byte = hrdata[23:16];
            default: ld_byte = hrdata[31:24];
        endcase
        ld_half = addr_q[1] ? hrdata[31:16] : hrdata[15:0];
        case (typ_q[1:0])
            2'b00:   load_data = {{24{ld_byte[7] & ~typ_q[2]}}, ld_byte};
            2'b01:   load_data = {{16{ld_half[15] & ~typ_q[2]}}, ld_half};
            default: load_data = hrdata;
        endcase
    end

    // The hready=0/hresp=1 first error cycle is an ordinary wait in DATA
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lsu_req_vld) state_nxt = req_illegal ? RESP : ADDR;
            ADDR:    if (hready)      state_nxt = DATA;
            DATA:    if (hready)      state_nxt = RESP;
            RESP:    if (lsu_rsp_rdy) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wen_q   <= 1'b0;
            typ_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == IDLE && lsu_req_vld) begin
            wen_q   <= lsu_req_wen;
            typ_q   <= lsu_req_rwtyp;
            addr_q  <= lsu_req_addr;
            wdata_q <= wdata_rep;
            rdata_q <= '0;
            err_q   <= req_illegal;
        end else if (state == DATA && hready) begin
            err_q   <= hresp;
            rdata_q <= (hresp || wen_q) ? '0 : load_data;
        end
    end

    // Every output comes from a flop or from the state alone
    assign lsu_req_rdy   = (state == IDLE);
    assign lsu_rsp_vld   = (state == RESP);
    assign lsu_rsp_rdata = rdata_q;
    assign lsu_rsp_err   = err_q;
    assign htrans        = (state == ADDR) ? 2'b10 : 2'b00;
    assign haddr         = addr_q;
    assign hwrite        = wen_q;
    assign hsize         = {1'b0, typ_q[1:0]};
    assign hburst        = '0;
    assign hwdata        = wdata_q;

endmodule

// File: tb/tb_lsu_ahb_master.sv
module tb_lsu_ahb_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        lsu_req_vld = 1'b0;
    logic        lsu_req_rdy;
    logic        lsu_req_wen = 1'b0;
    logic [2:0]  lsu_req_rwtyp = '0;
    logic [31:0] lsu_req_addr = '0;
    logic [31:0] lsu_req_wdata = '0;
    logic        lsu_rsp_vld;
    logic        lsu_rsp_rdy = 1'b0;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    lsu_ahb_master dut (
        .clk(clk), .rstn(rstn),
        .lsu_req_vld(lsu_req_vld), .lsu_req_rdy(lsu_req_rdy),
        .lsu_req_wen(lsu_req_wen), .lsu_req_rwtyp(lsu_req_rwtyp),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
        .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_rdy(lsu_rsp_rdy),
        .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (arithmetic on the access rules) -------
    function automatic bit ref_legal(input logic [2:0] typ, input logic [31:0] addr);
        case (typ)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (addr % 2) == 0;
            3'd2:       return (addr % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] typ, input logic [31:0] addr,
                                             input logic [31:0] rd);
        longint unsigned v;
        int unsigned off;
        off = addr % 4;
        if (typ == 3'd2) return rd;
        if (typ == 3'd0 || typ == 3'd4) begin
            v = (longint'(rd) >> (off * 8)) % 256;
            if (typ == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
        end else begin
            v = (longint'(rd) >> ((off / 2) * 16)) % 65536;
            if (typ == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_hwdata(input logic [2:0] typ, input logic [31:0] wd);
        longint unsigned v;
        if (typ % 4 == 0) v = (wd % 256) * 64'h0101_0101;
        else if (typ % 4 == 1) v = (wd % 65536) * 64'h0001_0001;
        else v = wd;
        return v[31:0];
    endfunction

    // ---------------- transaction driver with inline checks -----------------
    // Called at posedge+1 with the DUT idle. aw/dw are wait states in the
    // address/data phase, hold is the number of cycles rsp_rdy stays low.
    task automatic drive_txn(input logic wen, input logic [2:0] typ, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rd,
                             input int unsigned aw, input int unsigned dw,
                             input int unsigned hold, input bit err_inj);
        bit          legal;
        logic        exp_err;
        logic [31:0] exp_rd;
        legal   = ref_legal(typ, addr);
        exp_err = !legal || err_inj;
        exp_rd  = (exp_err || wen) ? 32'h0 : ref_load(typ, addr, rd);

        n_checks++;
        if (lsu_req_rdy !== 1'b1) begin
            n_fail++; $display("FAIL req_rdy_idle: got %b expected 1", lsu_req_rdy);
        end
        lsu_req_vld = 1'b1; lsu_req_wen = wen; lsu_req_rwtyp = typ;
        lsu_req_addr = addr; lsu_req_wdata = wdata;
        @(posedge clk); #1;
        lsu_req_vld = 1'b0; lsu_req_wdata = $urandom; lsu_req_addr = $urandom;

        if (legal) begin
            for (int unsigned i = 0; i <= aw; i++) begin
                n_checks++;
                if (htrans !== 2'b10 || haddr !== addr || hsize !== {1'b0, typ[1:0]} ||
                    hwrite !== wen || lsu_rsp_vld !== 1'b0) begin
                    n_fail++;
                    $display("FAIL addr_phase[%0d]: got htrans=%b haddr=%h hsize=%b hwrite=%b rsp_vld=%b expected 10 %h %b %b 0",
                             i, htrans, haddr, hsize, hwrite, lsu_rsp_vld, addr, {1'b0, typ[1:0]}, wen);
                end
                hready = (i == aw); hresp = 1'b0; hrdata = $urandom;
                @(posedge clk); #1;
            end
            for (int unsigned j = 0; j <= dw; j++) begin
                n_checks++;
                if (htrans !== 2'b00 || lsu_rsp_vld !== 1'b0 ||
                    (wen && hwdata !== ref_hwdata(typ, wdata))) begin
                    n_fail++;
                    $display("FAIL data_phase[%0d]: got htrans=%b rsp_vld=%b hwdata=%h expected 00 0 %h",
                             j, htrans, lsu_rsp_vld, hwdata, ref_hwdata(typ, wdata));
                end
                hready = (j == dw); hresp = err_inj && (j + 1 >= dw); hrdata = rd;
                @(posedge clk); #1;
            end
            hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
        end

        n_checks++;
        if (lsu_rsp_vld !== 1'b1 || htrans !== 2'b00 || lsu_rsp_rdata !== exp_rd ||
            lsu_rsp_err !== exp_err) begin
            n_fail++;
            $display("FAIL response: got vld=%b htrans=%b rdata=%h err=%b expected 1 00 %h %b",
                     lsu_rsp_vld, htrans, lsu_rsp_rdata, lsu_rsp_err, exp_rd, exp_err);
        end
        for (int unsigned k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (lsu_rsp_vld !== 1'b1 || lsu_req_rdy !== 1'b0 || lsu_rsp_rdata !== exp_rd ||
                lsu_rsp_err !== exp_err || htrans !== 2'b00) begin
                n_fail++;
                $display("FAIL rsp_hold[%0d]: got vld=%b req_rdy=%b rdata=%h err=%b expected 1 0 %h %b",
                         k, lsu_rsp_vld, lsu_req_rdy, lsu_rsp_rdata, lsu_rsp_err, exp_rd, exp_err);
            end
        end
        lsu_rsp_rdy = 1'b1;
        @(posedge clk); #1;
        lsu_rsp_rdy = 1'b0;
        n_checks++;
        if (lsu_rsp_vld !== 1'b0 || lsu_req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_release: got vld=%b req_rdy=%b expected 0 1", lsu_rsp_vld, lsu_req_rdy);
        end
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (lsu_req_rdy !== 1'b1 || lsu_rsp_vld !== 1'b0 || lsu_rsp_rdata !== 32'h0 ||
            lsu_rsp_err !== 1'b0 || htrans !== 2'b00 || haddr !== 32'h0 || hwrite !== 1'b0 ||
            hsize !== 3'b000 || hwdata !== 32'h0 || hburst !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b rdata=%h err=%b htrans=%b haddr=%h hwrite=%b hsize=%b hwdata=%h hburst=%b expected 1 0 0 0 00 0 0 000 0 000",
                     lsu_req_rdy, lsu_rsp_vld, lsu_rsp_rdata, lsu_rsp_err, htrans, haddr,
                     hwrite, hsize, hwdata, hburst);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        drive_txn(1'b0, 3'b010, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
        drive_txn(1'b0, 3'b000, 32'h2000_0003, 32'h0, 32'h8000_0000, 0, 0, 0, 1'b0);
        drive_txn(1'b0, 3'b100, 32'h2000_0003, 32'h0, 32'h8000_0000, 0, 0, 0, 1'b0);
        drive_txn(1'b0, 3'b001, 32'h2000_0002, 32'h0, 32'h8001_0000, 0, 0, 0, 1'b0);
        drive_txn(1'b0, 3'b101, 32'h2000_0000, 32'h0, 32'h1234_F00D, 0, 0, 0, 1'b0);
    endtask

    task automatic test_stores();
        drive_txn(1'b1, 3'b000, 32'h3000_0001, 32'h0000_00A5, 32'h5555_5555, 0, 0, 0, 1'b0);
        drive_txn(1'b1, 3'b001, 32'h3000_0002, 32'h0000_1234, 32'h5555_5555, 0, 0, 0, 1'b0);
        drive_txn(1'b1, 3'b010, 32'h3000_0008, 32'hCAFE_F00D, 32'h5555_5555, 0, 0, 0, 1'b0);
    endtask

    task automatic test_wait_states();
        drive_txn(1'b0, 3'b010, 32'h1000_0010, 32'h0, 32'h0BAD_CAFE, 3, 2, 4, 1'b0);
        drive_txn(1'b1, 3'b001, 32'h1000_0012, 32'hFFFF_8001, 32'h0, 1, 3, 2, 1'b0);
    endtask

    task automatic test_errors();
        drive_txn(1'b0, 3'b010, 32'h1000_0002, 32'h0, 32'h1111_1111, 0, 0, 0, 1'b0);
        drive_txn(1'b0, 3'b111, 32'h1000_0000, 32'h0, 32'h1111_1111, 0, 0, 1, 1'b0);
        drive_txn(1'b1, 3'b001, 32'h1000_0001, 32'h0, 32'h1111_1111, 0, 0, 0, 1'b0);
        drive_txn(1'b0, 3'b010, 32'h1000_0020, 32'h0, 32'h2222_2222, 0, 1, 0, 1'b1);
        drive_txn(1'b1, 3'b000, 32'h1000_0021, 32'h77, 32'h0, 2, 3, 1, 1'b1);
    endtask

    task automatic test_async_reset();
        lsu_req_vld = 1'b1; lsu_req_wen = 1'b0; lsu_req_rwtyp = 3'b010;
        lsu_req_addr = 32'h4000_0000;
        @(posedge clk); #1;
        lsu_req_vld = 1'b0; hready = 1'b1;
        n_checks++;
        if (htrans !== 2'b10) begin
            n_fail++; $display("FAIL rst_pre_addr: got htrans=%b expected 10", htrans);
        end
        @(posedge clk); #1;
        hready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (htrans !== 2'b00 || lsu_req_rdy !== 1'b1 || lsu_rsp_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got htrans=%b req_rdy=%b rsp_vld=%b expected 00 1 0",
                     htrans, lsu_req_rdy, lsu_rsp_vld);
        end
        @(posedge clk); #1;
        rstn = 1'b1; hready = 1'b1;
        @(posedge clk); #1;
        drive_txn(1'b0, 3'b010, 32'h4000_0004, 32'h0, 32'h600D_F00D, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] typs [8];
        typs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  typ;
            int unsigned aw, dw;
            bit          err;
            typ = (($urandom % 10) == 0) ? 3'd7 : typs[$urandom % 8];
            aw  = $urandom % 3;
            dw  = $urandom % 3;
            err = ($urandom % 6) == 0;
            if (err && dw == 0) dw = 1;
            drive_txn(1'($urandom % 2), typ, $urandom, $urandom, $urandom, aw, dw,
                      $urandom % 3, err);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_wait_states();
        test_errors();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
